// File: rtl/benes_pkg.sv
// Shared helpers for the pipelined Benes network: stage count, config width
// and the switch-to-lane mapping of every column.
package benes_pkg;

    function automatic int num_stages(input int log2p);
        return 2 * log2p - 1;
    endfunction

    function automatic int cfg_width(input int log2p);
        return (2 * log2p - 1) * (1 << (log2p - 1));
    endfunction

    // Bit position that distinguishes the two lanes of a switch in stage s.
    function automatic int stage_bit(input int s, input int log2p);
        return (s < log2p) ? (log2p - 1 - s) : (s - log2p + 1);
    endfunction

    function automatic int stage_dist(input int s, input int log2p);
        return 1 << stage_bit(s, log2p);
    endfunction

    // k-th lane (ascending) whose stage bit is 0: insert a 0 at that bit of k.
    function automatic int pair_lane(input int s, input int k, input int log2p);
        int b;
        b = stage_bit(s, log2p);
        return ((k >> b) << (b + 1)) | (k & ((1 << b) - 1));
    endfunction

endpackage

// File: rtl/benes_stage.sv
// One Benes column of P/2 switches followed by a pipeline register that also
// carries the select bits still needed by later columns.
module benes_stage
    import benes_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int LOG2P = 2,
    parameter  int STAGE = 0,
    localparam int P     = 1 << LOG2P,
    localparam int HALF  = P / 2,
    localparam int S     = num_stages(LOG2P),
    localparam int SI_W  = (S - STAGE) * HALF,
    localparam int SO_W  = (STAGE < S - 1) ? SI_W - HALF : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adv,
    input  logic            valid_in,
    input  logic [P*N-1:0]  data_in,
    input  logic [SI_W-1:0] sel_in,
    output logic            valid_q,
    output logic [P*N-1:0]  data_q,
    output logic [SO_W-1:0] sel_q
);

    logic [N-1:0]   lane_sw [P];
    logic [P*N-1:0] data_sw;

    for (genvar k = 0; k < HALF; k++) begin : g_sw
        localparam int A = pair_lane(STAGE, k, LOG2P);
        localparam int B = A + stage_dist(STAGE, LOG2P);
        crbar2 #(.N(N)) u_sw (
            .sel   (sel_in[k]),
            .a_in  (data_in[A*N +: N]),
            .b_in  (data_in[B*N +: N]),
            .a_out (lane_sw[A]),
            .b_out (lane_sw[B])
        );
    end

    for (genvar i = 0; i < P; i++) begin : g_pack
        assign data_sw[i*N +: N] = lane_sw[i];
    end

    // NOTE: sequential state uses non-blocking assignments so every column
    // samples its predecessor's pre-edge value and the pipeline shifts as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (adv) begin
            valid_q <= valid_in;
            data_q  <= valid_in ? data_sw : '0;
        end
    end

    if (STAGE < S - 1) begin : g_sel
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                sel_q <= '0;
            else if (adv)
                sel_q <= valid_in ? sel_in[SI_W-1:HALF] : '0;
        end
    end else begin : g_last
        assign sel_q = '0;
    end

endmodule

// File: rtl/crbar2.sv
// 2x2 crossbar switch: straight when sel=0, swapped when sel=1.
module crbar2 #(
    parameter int N = 32
) (
    input  logic         sel,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out
);

    assign a_out = sel ? b_in : a_in;
    assign b_out = sel ? a_in : b_in;

endmodule

// File: rtl/benes_pipe_net.sv
// Pipelined Benes permutation network: each vector carries its own switch
// selects through the columns, so reconfiguration never needs a flush.
module benes_pipe_net
    import benes_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int Q     = 15,
    parameter  int LOG2P = 2,
    localparam int P     = 1 << LOG2P,
    localparam int HALF  = P / 2,
    localparam int S     = num_stages(LOG2P),
    localparam int W     = cfg_width(LOG2P)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [P*N-1:0] in_data,
    input  logic           cfg_we,
    input  logic [W-1:0]   cfg_bits,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P*N-1:0] out_data,
    output logic [W-1:0]   cfg_q
);

    if (LOG2P < 1 || Q < 0 || Q >= N) begin : g_bad_params
        $error("benes_pipe_net: need LOG2P >= 1 and 0 <= Q < N");
    end

    logic           adv;
    logic           accept;
    logic [W-1:0]   cfg_sel;
    logic           v_chain [S+1];
    logic [P*N-1:0] d_chain [S+1];
    logic [HALF-1:0] sel_tail_unused;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    // A config written alongside a vector applies to that vector.
    assign cfg_sel  = cfg_we ? cfg_bits : cfg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg_q <= '0;
        else if (cfg_we)
            cfg_q <= cfg_bits;
    end

    assign v_chain[0] = accept;
    assign d_chain[0] = in_data;

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int SI_W = (S - s) * HALF;
        localparam int SO_W = (s < S - 1) ? SI_W - HALF : 1;
        logic [SI_W-1:0] s_in;
        logic [SO_W-1:0] s_q;

        if (s == 0) begin : g_head
            assign s_in = cfg_sel;
        end else begin : g_link
            assign s_in = g_stage[s-1].s_q;
        end

        benes_stage #(.N(N), .LOG2P(LOG2P), .STAGE(s)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .valid_in (v_chain[s]),
            .data_in  (d_chain[s]),
            .sel_in   (s_in),
            .valid_q  (v_chain[s+1]),
            .data_q   (d_chain[s+1]),
            .sel_q    (s_q)
        );
    end

    assign sel_tail_unused = HALF'(g_stage[S-1].s_q);
    assign out_valid       = v_chain[S];
    assign out_data        = d_chain[S];

endmodule

// File: tb/tb_benes_pipe_net.sv
// Scoreboard bench for benes_pipe_net (P=4, N=32): stimulus pushes hand-computed
// expected vectors, a negedge monitor pops and compares on each output handshake.
module tb_benes_pipe_net;

    localparam int N  = 32;
    localparam int P  = 4;
    localparam int W  = 6;
    localparam int PN = P * N;

    localparam logic [31:0] X0 = 32'h0008_0000;
    localparam logic [31:0] X1 = 32'h0010_0000;
    localparam logic [31:0] X2 = 32'h0018_0000;
    localparam logic [31:0] X3 = 32'h0020_0000;

    typedef struct {
        logic [PN-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PN-1:0] in_data;
    logic          cfg_we;
    logic [W-1:0]  cfg_bits;
    logic          out_valid;
    logic          out_ready;
    logic [PN-1:0] out_data;
    logic [W-1:0]  cfg_q;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    benes_pipe_net #(.N(N), .Q(15), .LOG2P(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_bits  (cfg_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_q     (cfg_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PN-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                            input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [PN-1:0] act, input logic [PN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got=%h at cycle %0d", out_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                if (mon_e.due >= 0)
                    check("latency_cycle", PN'(cyc), PN'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PN-1:0] data, input logic [W-1:0] cfg, input logic we,
                        input logic [PN-1:0] exp, input bit push, input bit timed);
        int n;
        int t;
        in_valid = 1'b1;
        in_data  = data;
        cfg_we   = we;
        cfg_bits = cfg;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout got=in_ready_low exp=in_ready_high");
        end
        t = cyc;
        tick();
        if (push) sb.push_back('{exp, timed ? t + 3 : -1});
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        check("drain_pending", PN'(sb.size()), '0);
    endtask

    logic [PN-1:0] xs;
    logic [W-1:0]  tbl_cfg [7];
    logic [PN-1:0] tbl_exp [7];
    logic [PN-1:0] exp_a;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xs = lanes(X0, X1, X2, X3);
        tbl_cfg[0] = 6'b000000; tbl_exp[0] = lanes(X0, X1, X2, X3);
        tbl_cfg[1] = 6'b111111; tbl_exp[1] = lanes(X1, X0, X3, X2);
        tbl_cfg[2] = 6'b000001; tbl_exp[2] = lanes(X2, X1, X0, X3);
        tbl_cfg[3] = 6'b000100; tbl_exp[3] = lanes(X1, X0, X2, X3);
        tbl_cfg[4] = 6'b010000; tbl_exp[4] = lanes(X2, X1, X0, X3);
        tbl_cfg[5] = 6'b100000; tbl_exp[5] = lanes(X0, X3, X2, X1);
        tbl_cfg[6] = 6'b000110; tbl_exp[6] = lanes(X3, X0, X2, X1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cfg_we    = 1'b0;
        cfg_bits  = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", PN'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_cfg_q", PN'(cfg_q), '0);
        check("rst_in_ready", PN'(in_ready), PN'(1));
        rst_n = 1'b1;
        repeat (5) tick();

        // Single vectors, each with its own config written through
        for (int i = 0; i < 7; i++) begin
            send(xs, tbl_cfg[i], 1'b1, tbl_exp[i], 1'b1, 1'b1);
            drain();
        end
        check("cfg_q_after_table", PN'(cfg_q), PN'(6'b000110));

        // Config loaded on its own, then used from cfg_q
        cfg_we   = 1'b1;
        cfg_bits = 6'b001100;
        tick();
        cfg_we   = 1'b0;
        check("cfg_q_load", PN'(cfg_q), PN'(6'b001100));
        send(xs, 6'b000000, 1'b0, lanes(X1, X0, X3, X2), 1'b1, 1'b1);
        drain();

        // Back-to-back vectors, each with a fresh config
        send(xs, 6'b000000, 1'b1, lanes(X0, X1, X2, X3), 1'b1, 1'b1);
        send(xs, 6'b111111, 1'b1, lanes(X1, X0, X3, X2), 1'b1, 1'b1);
        send(xs, 6'b000011, 1'b1, lanes(X2, X3, X0, X1), 1'b1, 1'b1);
        check("cfg_q_b2b", PN'(cfg_q), PN'(6'b000011));
        drain();

        // Stall with three vectors in flight
        out_ready = 1'b0;
        exp_a = lanes(X2, X1, X0, X3);
        send(xs, 6'b000001, 1'b1, exp_a, 1'b1, 1'b0);
        send(xs, 6'b100000, 1'b1, lanes(X0, X3, X2, X1), 1'b1, 1'b0);
        send(xs, 6'b000000, 1'b1, lanes(X0, X1, X2, X3), 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", PN'(out_valid), PN'(1));
            check("stall_in_ready", PN'(in_ready), '0);
            check("stall_out_data", out_data, exp_a);
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Reset with two vectors in the first columns
        send(xs, 6'b111111, 1'b1, '0, 1'b0, 1'b0);
        send(xs, 6'b000011, 1'b1, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", PN'(out_valid), '0);
        check("midrst_cfg_q", PN'(cfg_q), '0);
        check("midrst_out_data", out_data, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        send(xs, 6'b000110, 1'b1, lanes(X3, X0, X2, X1), 1'b1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
